// File: rtl/cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter
//   Shares the single line-granularity memory port (EWB -> cacheline adaptor)
//   between the I-cache and the D-cache, one transaction in flight at a time.
//   A grant FSM (IDLE -> GNT_I/GNT_D -> DRAIN -> IDLE) holds the grant until
//   arb_mem_resp, then spends one DRAIN cycle so the served cache can drop
//   its stale request before the next decision.
//
//   Tie policy (both caches requesting in IDLE):
//     default             : D-cache wins, unless the I-cache has already been
//                           passed over STARVE_LIMIT times in a row.
//     ARB_ROUND_ROBIN_EN  : the requester not served last wins (last_gnt
//                           resets to I, so D wins the first tie).
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   arb_icache_*  (in)          I-cache read/write/address/wdata request
//   arb_icache_resp/rdata (out) I-cache completion pulse and read line
//   arb_dcache_*  (in)          D-cache read/write/address/wdata request
//   arb_dcache_resp/rdata (out) D-cache completion pulse and read line
//   arb_mem_read/write/address/wdata (out)  request towards the EWB
//   arb_mem_resp/rdata (in)     EWB completion pulse and read line
// -----------------------------------------------------------------------------

// Flags a requester that drives read and write at the same time.
module cache_mem_arbiter_checker (
    input logic clk,
    input logic rst,
    input logic icache_read_i,
    input logic icache_write_i,
    input logic dcache_read_i,
    input logic dcache_write_i
);
    a_icache_no_rw: assert property (@(posedge clk) disable iff (rst)
        !(icache_read_i && icache_write_i));
    a_dcache_no_rw: assert property (@(posedge clk) disable iff (rst)
        !(dcache_read_i && dcache_write_i));
endmodule

module cache_mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         arb_icache_read,
    input  logic         arb_icache_write,
    input  logic [31:0]  arb_icache_address,
    input  logic [255:0] arb_icache_wdata,
    output logic         arb_icache_resp,
    output logic [255:0] arb_icache_rdata,
    input  logic         arb_dcache_read,
    input  logic         arb_dcache_write,
    input  logic [31:0]  arb_dcache_address,
    input  logic [255:0] arb_dcache_wdata,
    output logic         arb_dcache_resp,
    output logic [255:0] arb_dcache_rdata,
    output logic         arb_mem_read,
    output logic         arb_mem_write,
    output logic [31:0]  arb_mem_address,
    output logic [255:0] arb_mem_wdata,
    input  logic         arb_mem_resp,
    input  logic [255:0] arb_mem_rdata
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GNT_I = 2'd1;
    localparam logic [1:0] GNT_D = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       req_i_s;
    logic       req_d_s;
    logic       pick_i_s;   // tie-break result: 1 = I-cache wins a tie
    logic       gnt_i_s;    // I-grant taken this cycle (IDLE only)
    logic       gnt_d_s;    // D-grant taken this cycle (IDLE only)

    assign req_i_s = arb_icache_read | arb_icache_write;
    assign req_d_s = arb_dcache_read | arb_dcache_write;

`ifdef ARB_ROUND_ROBIN_EN
    // 1'b1 = D-cache was served last, 1'b0 = I-cache was served last.
    logic last_gnt_q;
    logic last_gnt_d;

    assign pick_i_s = last_gnt_q;

    // Remember which requester took the most recent grant.
    always_comb begin
        last_gnt_d = last_gnt_q;
        if (gnt_i_s) begin
            last_gnt_d = 1'b0;
        end else if (gnt_d_s) begin
            last_gnt_d = 1'b1;
        end else begin
            last_gnt_d = last_gnt_q;
        end
    end

    // Last-grant register; resets to I so the first tie goes to D.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_q <= 1'b0;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end
`else
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;

    assign pick_i_s = (starve_cnt_q == LIMIT_C);

    // Count D-grants that bypass a waiting I-request; any I-grant or an
    // idle cycle without an I-request resets the count.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (gnt_i_s) begin
            starve_cnt_d = {CNT_W{1'b0}};
        end else if (gnt_d_s && req_i_s) begin
            if (starve_cnt_q != LIMIT_C) begin
                starve_cnt_d = starve_cnt_q + ONE_C;
            end else begin
                starve_cnt_d = starve_cnt_q;
            end
        end else if ((state_q == IDLE) && !req_i_s) begin
            starve_cnt_d = {CNT_W{1'b0}};
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= {CNT_W{1'b0}};
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`endif

    // Grant decision, only meaningful while IDLE.
    always_comb begin
        gnt_i_s = 1'b0;
        gnt_d_s = 1'b0;
        if (state_q == IDLE) begin
            if (req_i_s && req_d_s) begin
                gnt_i_s = pick_i_s;
                gnt_d_s = ~pick_i_s;
            end else begin
                gnt_i_s = req_i_s;
                gnt_d_s = req_d_s;
            end
        end else begin
            gnt_i_s = 1'b0;
            gnt_d_s = 1'b0;
        end
    end

    // Grant FSM next state; a memory response outside a grant is ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (gnt_i_s) begin
                    state_d = GNT_I;
                end else if (gnt_d_s) begin
                    state_d = GNT_D;
                end else begin
                    state_d = IDLE;
                end
            end
            GNT_I, GNT_D: begin
                if (arb_mem_resp) begin
                    state_d = DRAIN;
                end else begin
                    state_d = state_q;
                end
            end
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Memory-port mux and response routing; everything is 0 outside a grant.
    // Write has precedence when a requester drives read and write together.
    always_comb begin
        arb_mem_read     = 1'b0;
        arb_mem_write    = 1'b0;
        arb_mem_address  = 32'd0;
        arb_mem_wdata    = 256'd0;
        arb_icache_resp  = 1'b0;
        arb_icache_rdata = 256'd0;
        arb_dcache_resp  = 1'b0;
        arb_dcache_rdata = 256'd0;
        case (state_q)
            GNT_I: begin
                arb_mem_write    = arb_icache_write;
                arb_mem_read     = arb_icache_read & ~arb_icache_write;
                arb_mem_address  = arb_icache_address;
                arb_mem_wdata    = arb_icache_wdata;
                arb_icache_resp  = arb_mem_resp;
                arb_icache_rdata = arb_mem_resp ? arb_mem_rdata : 256'd0;
            end
            GNT_D: begin
                arb_mem_write    = arb_dcache_write;
                arb_mem_read     = arb_dcache_read & ~arb_dcache_write;
                arb_mem_address  = arb_dcache_address;
                arb_mem_wdata    = arb_dcache_wdata;
                arb_dcache_resp  = arb_mem_resp;
                arb_dcache_rdata = arb_mem_resp ? arb_mem_rdata : 256'd0;
            end
            default: begin
                arb_mem_read     = 1'b0;
                arb_mem_write    = 1'b0;
            end
        endcase
    end

    cache_mem_arbiter_checker u_checker (
        .clk            (clk),
        .rst            (rst),
        .icache_read_i  (arb_icache_read),
        .icache_write_i (arb_icache_write),
        .dcache_read_i  (arb_dcache_read),
        .dcache_write_i (arb_dcache_write)
    );

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter. A latency-programmable EWB model
// answers granted requests; expected transactions are queued when the caches
// raise requests and checked against each resp pulse.
module tb_cache_mem_arbiter;
    logic         clk;
    logic         rst;
    logic         arb_icache_read;
    logic         arb_icache_write;
    logic [31:0]  arb_icache_address;
    logic [255:0] arb_icache_wdata;
    logic         arb_icache_resp;
    logic [255:0] arb_icache_rdata;
    logic         arb_dcache_read;
    logic         arb_dcache_write;
    logic [31:0]  arb_dcache_address;
    logic [255:0] arb_dcache_wdata;
    logic         arb_dcache_resp;
    logic [255:0] arb_dcache_rdata;
    logic         arb_mem_read;
    logic         arb_mem_write;
    logic [31:0]  arb_mem_address;
    logic [255:0] arb_mem_wdata;
    logic         arb_mem_resp;
    logic [255:0] arb_mem_rdata;

    typedef struct {
        logic         is_i;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic [255:0] rdata;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   mem_lat = 5;
    int   wait_cnt = 0;
    logic spurious = 1'b0;
    logic hold_i = 1'b0;
    logic hold_d = 1'b0;
    logic pend_drop_i = 1'b0;
    logic pend_drop_d = 1'b0;

    cache_mem_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk                (clk),
        .rst                (rst),
        .arb_icache_read    (arb_icache_read),
        .arb_icache_write   (arb_icache_write),
        .arb_icache_address (arb_icache_address),
        .arb_icache_wdata   (arb_icache_wdata),
        .arb_icache_resp    (arb_icache_resp),
        .arb_icache_rdata   (arb_icache_rdata),
        .arb_dcache_read    (arb_dcache_read),
        .arb_dcache_write   (arb_dcache_write),
        .arb_dcache_address (arb_dcache_address),
        .arb_dcache_wdata   (arb_dcache_wdata),
        .arb_dcache_resp    (arb_dcache_resp),
        .arb_dcache_rdata   (arb_dcache_rdata),
        .arb_mem_read       (arb_mem_read),
        .arb_mem_write      (arb_mem_write),
        .arb_mem_address    (arb_mem_address),
        .arb_mem_wdata      (arb_mem_wdata),
        .arb_mem_resp       (arb_mem_resp),
        .arb_mem_rdata      (arb_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // EWB model: answers after mem_lat waiting cycles with a 1-cycle pulse.
    initial begin
        arb_mem_resp = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (arb_mem_resp) begin
                arb_mem_resp = 1'b0;
                wait_cnt     = 0;
            end else if (spurious) begin
                arb_mem_resp = 1'b1;
            end else if (arb_mem_read || arb_mem_write) begin
                if (wait_cnt == mem_lat) begin
                    arb_mem_resp = 1'b1;
                    wait_cnt     = 0;
                end else begin
                    wait_cnt = wait_cnt + 1;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic is_i, input logic wr, input logic [31:0] addr,
                            input logic [255:0] wdata);
        exp_t e;
        e.is_i  = is_i;
        e.wr    = wr;
        e.addr  = addr;
        e.wdata = wdata;
        e.rdata = arb_mem_rdata;
        sb_q.push_back(e);
    endtask

    // One clock: apply pending request drops, then score any resp pulse.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (pend_drop_i && !hold_i) begin
            arb_icache_read  = 1'b0;
            arb_icache_write = 1'b0;
        end
        if (pend_drop_d && !hold_d) begin
            arb_dcache_read  = 1'b0;
            arb_dcache_write = 1'b0;
        end
        pend_drop_i = 1'b0;
        pend_drop_d = 1'b0;
        #1;
        if (arb_icache_resp || arb_dcache_resp) begin
            chk_b("single_resp", arb_icache_resp & arb_dcache_resp, 1'b0);
            chk_b("resp_expected", sb_q.size() > 0, 1'b1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk_b("resp_owner", arb_icache_resp, e.is_i);
                chk_w("resp_addr", 256'(arb_mem_address), 256'(e.addr));
                chk_b("resp_write", arb_mem_write, e.wr);
                chk_b("resp_read", arb_mem_read, ~e.wr);
                chk_w("resp_wdata", arb_mem_wdata, e.wdata);
                chk_w("resp_rdata", e.is_i ? arb_icache_rdata : arb_dcache_rdata, e.rdata);
                chk_w("other_rdata", e.is_i ? arb_dcache_rdata : arb_icache_rdata, 256'd0);
                if (e.is_i) pend_drop_i = 1'b1;
                else        pend_drop_d = 1'b1;
            end
        end
    endtask

    task automatic run_until_size(input int n, input int budget);
        int k = 0;
        while (sb_q.size() > n && k < budget) begin
            step();
            k++;
        end
        chk_b("resp_timeout", sb_q.size() <= n, 1'b1);
    endtask

    task automatic check_quiet(input string tag, input logic [1:0] exp_state);
        chk_w({tag, "_state"}, 256'(dut.state_q), 256'(exp_state));
        chk_b({tag, "_mem_read"}, arb_mem_read, 1'b0);
        chk_b({tag, "_mem_write"}, arb_mem_write, 1'b0);
        chk_b({tag, "_iresp"}, arb_icache_resp, 1'b0);
        chk_b({tag, "_dresp"}, arb_dcache_resp, 1'b0);
        chk_w({tag, "_addr"}, 256'(arb_mem_address), 256'd0);
        chk_w({tag, "_wdata"}, arb_mem_wdata, 256'd0);
        chk_w({tag, "_irdata"}, arb_icache_rdata, 256'd0);
        chk_w({tag, "_drdata"}, arb_dcache_rdata, 256'd0);
    endtask

    initial begin
        // Reset with both caches requesting.
        rst                = 1'b1;
        arb_icache_read    = 1'b1;
        arb_icache_write   = 1'b0;
        arb_icache_address = 32'h0000_0100;
        arb_icache_wdata   = 256'd0;
        arb_dcache_read    = 1'b1;
        arb_dcache_write   = 1'b0;
        arb_dcache_address = 32'h0000_0200;
        arb_dcache_wdata   = 256'd0;
        arb_mem_rdata      = {8{32'hDEAD_BEEF}};
        step();
        step();
        check_quiet("reset", 2'd0);
`ifndef ARB_ROUND_ROBIN_EN
        chk_w("reset_starve", 256'(dut.starve_cnt_q), 256'd0);
`endif
        rst             = 1'b0;
        arb_icache_read = 1'b0;
        arb_dcache_read = 1'b0;
        step();
        check_quiet("idle", 2'd0);

        // Lone I-cache read, 5 wait cycles.
        mem_lat            = 5;
        arb_icache_read    = 1'b1;
        arb_icache_address = 32'h0000_0060;
        push_exp(1'b1, 1'b0, 32'h0000_0060, 256'd0);
        step();
        chk_w("ird_state", 256'(dut.state_q), 256'd1);
        chk_b("ird_mem_read", arb_mem_read, 1'b1);
        chk_w("ird_addr", 256'(arb_mem_address), 256'h60);
        chk_b("ird_dresp", arb_dcache_resp, 1'b0);
        run_until_size(0, 20);
        step();
        check_quiet("ird_drain", 2'd3);
        step();
        check_quiet("ird_idle", 2'd0);

        // Simultaneous I read and D write: D first.
        arb_mem_rdata      = {8{32'h1234_5678}};
        arb_icache_read    = 1'b1;
        arb_icache_address = 32'h0000_0100;
        arb_dcache_write   = 1'b1;
        arb_dcache_address = 32'h0000_0200;
        arb_dcache_wdata   = {8{32'hA5A5_A5A5}};
        push_exp(1'b0, 1'b1, 32'h0000_0200, {8{32'hA5A5_A5A5}});
        push_exp(1'b1, 1'b0, 32'h0000_0100, 256'd0);
        step();
        chk_b("tie_mem_write", arb_mem_write, 1'b1);
        chk_b("tie_mem_read", arb_mem_read, 1'b0);
        chk_w("tie_addr", 256'(arb_mem_address), 256'h200);
        chk_w("tie_wdata", arb_mem_wdata, {8{32'hA5A5_A5A5}});
        run_until_size(1, 20);
        step();
        check_quiet("tie_drain", 2'd3);
        step();
        check_quiet("tie_idle", 2'd0);
        step();
        chk_b("tie_i_read", arb_mem_read, 1'b1);
        chk_w("tie_i_addr", 256'(arb_mem_address), 256'h100);
        run_until_size(0, 20);
        step();
        step();
        arb_dcache_wdata = 256'd0;

        // Both caches requesting continuously.
        mem_lat            = 1;
        hold_i             = 1'b1;
        hold_d             = 1'b1;
        arb_mem_rdata      = {8{32'h0BAD_F00D}};
        arb_icache_read    = 1'b1;
        arb_icache_address = 32'h0000_0400;
        arb_dcache_read    = 1'b1;
        arb_dcache_address = 32'h0000_0300;
`ifndef ARB_ROUND_ROBIN_EN
        for (int i = 0; i < 4; i++) push_exp(1'b0, 1'b0, 32'h0000_0300, 256'd0);
        push_exp(1'b1, 1'b0, 32'h0000_0400, 256'd0);
        step();
        chk_w("starve_first", 256'(dut.starve_cnt_q), 256'd1);
`else
        for (int i = 0; i < 4; i++) begin
            push_exp(1'b0, 1'b0, 32'h0000_0300, 256'd0);
            push_exp(1'b1, 1'b0, 32'h0000_0400, 256'd0);
        end
`endif
        run_until_size(0, 200);
        hold_i          = 1'b0;
        hold_d          = 1'b0;
        arb_icache_read = 1'b0;
        arb_dcache_read = 1'b0;
        step();
        check_quiet("cont_drain", 2'd3);
`ifndef ARB_ROUND_ROBIN_EN
        chk_w("starve_cleared", 256'(dut.starve_cnt_q), 256'd0);
`endif
        step();

        // Stray memory response in IDLE must not be forwarded.
        spurious = 1'b1;
        step();
        spurious = 1'b0;
        check_quiet("stray", 2'd0);
        step();
        check_quiet("stray_after", 2'd0);

        // Reset while GNT_D is waiting on memory.
        mem_lat            = 10;
        arb_dcache_write   = 1'b1;
        arb_dcache_address = 32'h0000_0500;
        arb_dcache_wdata   = {8{32'hC3C3_C3C3}};
        step();
        chk_b("rst_gnt_write", arb_mem_write, 1'b1);
        chk_w("rst_gnt_addr", 256'(arb_mem_address), 256'h500);
        step();
        step();
        rst              = 1'b1;
        arb_dcache_write = 1'b0;
        arb_dcache_wdata = 256'd0;
        step();
        check_quiet("mid_rst", 2'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check_quiet("post_rst", 2'd0);
        chk_b("sb_empty", sb_q.size() == 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
